// File: rtl/bridge_pkg.sv
// Shared constants for the UART-to-bus bridge.
//   OP_WRITE / OP_READ : frame opcodes ('W', 'R')
//   RESP_OK / RESP_ERR : single-byte responses ('K', '?')
//   state_t            : bridge FSM state encoding
package bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_EXEC = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/bus_bridge.sv
// UART byte-stream to 32-bit peripheral bus bridge.
// Frames: opcode, 4 address bytes (MSB first), then 4 data bytes for writes.
// Writes answer 'K', reads answer the 4 captured data bytes (MSB first),
// bad opcodes and misaligned addresses answer '?' with an err pulse.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   rx_data, rx_valid : received byte and its one-cycle valid pulse
//   tx_data, tx_start : byte to send and its one-cycle start pulse
//   tx_busy           : transmitter busy
//   rd, wr            : one-cycle bus strobes
//   addr, wdata       : bus address / write data, held between frames
//   rdata             : bus read data, valid while rd is high
//   busy              : FSM not idle
//   err               : one-cycle protocol error pulse
module bus_bridge #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        err
);
    import bridge_pkg::*;

    // Wide enough to hold TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state;
    logic          is_write;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] timer;
    logic [23:0]   shift;      // first three bytes of the current word
    logic [31:0]   addr_pend;  // write address, committed together with wdata
    logic [31:0]   resp_buf;   // remaining response bytes, next byte in [31:24]
    logic [2:0]    resp_left;
    logic [31:0]   frame_word;

    // Word completed by the byte arriving this cycle.
    assign frame_word = {shift, rx_data};
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            timer     <= '0;
            shift     <= 24'h0;
            addr_pend <= 32'h0;
            resp_buf  <= 32'h0;
            resp_left <= 3'd0;
            addr      <= 32'h0;
            wdata     <= 32'h0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            err       <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h0;
        end else begin
            rd       <= 1'b0;
            wr       <= 1'b0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            is_write <= (rx_data == OP_WRITE);
                            byte_cnt <= 2'd0;
                            timer    <= '0;
                            state    <= ST_ADDR;
                        end else begin
                            err       <= 1'b1;
                            resp_buf  <= {RESP_ERR, 24'h0};
                            resp_left <= 3'd1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_ADDR, ST_DATA: begin
                    // A byte arriving on the timeout cycle takes priority.
                    if (rx_valid) begin
                        timer    <= '0;
                        byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 on the 4th byte
                        shift    <= frame_word[23:0];
                        if (byte_cnt == 2'd3) begin
                            if (state == ST_ADDR && is_write) begin
                                addr_pend <= frame_word;
                                state     <= ST_DATA;
                            end else if (state == ST_ADDR) begin
                                addr  <= frame_word;
                                rd    <= (frame_word[1:0] == 2'b00);
                                err   <= (frame_word[1:0] != 2'b00);
                                state <= ST_EXEC;
                            end else begin
                                addr  <= addr_pend;
                                wdata <= frame_word;
                                wr    <= (addr_pend[1:0] == 2'b00);
                                err   <= (addr_pend[1:0] != 2'b00);
                                state <= ST_EXEC;
                            end
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        err      <= 1'b1;
                        timer    <= '0;
                        byte_cnt <= 2'd0;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_EXEC: begin
                    // rd is high this cycle, so rdata is captured on this edge.
                    state <= ST_RESP;
                    if (addr[1:0] != 2'b00) begin
                        resp_buf  <= {RESP_ERR, 24'h0};
                        resp_left <= 3'd1;
                    end else if (is_write) begin
                        resp_buf  <= {RESP_OK, 24'h0};
                        resp_left <= 3'd1;
                    end else begin
                        resp_buf  <= rdata;
                        resp_left <= 3'd4;
                    end
                end
                ST_RESP: begin
                    // Skipping the cycle right after a start keeps starts at
                    // least two cycles apart, giving tx_busy time to rise.
                    if (!tx_busy && !tx_start) begin
                        tx_start  <= 1'b1;
                        tx_data   <= resp_buf[31:24];
                        resp_buf  <= {resp_buf[23:0], 8'h0};
                        resp_left <= resp_left - 3'd1;
                        if (resp_left == 3'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed frames, timeout boundaries,
// randomized frames against a frame-level reference model, and reset
// during a read response.
module tb_bus_bridge;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    logic [31:0] rdata_val = 32'h0;
    // Garbage outside rd, so a late capture is visible.
    assign rdata = rd ? rdata_val : 32'hDEAD_BEEF;

    bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic [31:0] wr_addr_seen, wr_data_seen, rd_addr_seen;
    logic [7:0]  tx_q[$];
    int busy_left = 0;
    int since_start = 99;
    bit toggle_mode = 1'b0;
    // Reference model: bus-visible address / write data.
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Bus/tx monitor plus a simple transmitter model driving tx_busy.
    always @(negedge clk) begin
        if (reset) begin
            if (tx_start) begin
                check("tx_start_while_busy", 32'(tx_busy), 32'd0);
                check("tx_start_spacing", 32'(since_start >= 2), 32'd1);
                tx_q.push_back(tx_data);
                since_start = 1;
            end else if (since_start < 99) begin
                since_start++;
            end
            if (wr) begin
                wr_cnt++;
                wr_addr_seen = addr;
                wr_data_seen = wdata;
            end
            if (rd) begin
                rd_cnt++;
                rd_addr_seen = addr;
            end
            if (err) err_cnt++;
        end else begin
            since_start = 99;
        end
        if (tx_start) busy_left = int'($urandom_range(4, 0));
        else if (busy_left > 0) busy_left--;
        tx_busy = toggle_mode ? 1'($urandom_range(1, 0)) : (busy_left != 0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic clear_mon();
        wr_cnt = 0;
        rd_cnt = 0;
        err_cnt = 0;
        tx_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({rd, wr, tx_start, err, busy}), 32'd0);
        check({tag, "_addr"}, addr, 32'h0);
        check({tag, "_wdata"}, wdata, 32'h0);
        check({tag, "_txdata"}, 32'(tx_data), 32'h0);
    endtask

    // One frame: model the expected outcome, send bytes, compare.
    task automatic do_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                          input int gap_lo, input int gap_hi, input bit stray);
        logic [7:0] bytes[$];
        logic [7:0] exp_tx[$];
        int exp_wr = 0, exp_rd = 0, exp_err = 0;
        int waited = 0;
        bit is_w = (op == 8'h57);
        bit is_r = (op == 8'h52);

        if (!is_w && !is_r) begin
            exp_err = 1;
            exp_tx.push_back(8'h3F);
        end else begin
            m_addr = a;
            if (is_w) m_wdata = d;
            if (a % 4 != 0) begin
                exp_err = 1;
                exp_tx.push_back(8'h3F);
            end else if (is_w) begin
                exp_wr = 1;
                exp_tx.push_back(8'h4B);
            end else begin
                exp_rd = 1;
                for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
            end
        end

        bytes.push_back(op);
        if (is_w || is_r) for (int i = 3; i >= 0; i--) bytes.push_back(a[i*8 +: 8]);
        if (is_w) for (int i = 3; i >= 0; i--) bytes.push_back(d[i*8 +: 8]);

        rdata_val = d;
        clear_mon();
        for (int i = 0; i < bytes.size(); i++) begin
            if (i > 0) idle(int'($urandom_range(gap_hi, gap_lo)));
            send_byte(bytes[i]);
        end
        // Lands in EXEC (full frame) or RESP (bad opcode): must be ignored.
        if (stray) send_byte(8'h41);

        while (!(tx_q.size() >= exp_tx.size() && !busy) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("txn_done", 32'(waited < 400), 32'd1);
        idle(6);

        check("err_count", 32'(err_cnt), 32'(exp_err));
        check("wr_count", 32'(wr_cnt), 32'(exp_wr));
        check("rd_count", 32'(rd_cnt), 32'(exp_rd));
        check("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size(); i++)
            if (i < tx_q.size()) check("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
        if (exp_wr != 0) begin
            check("wr_addr", wr_addr_seen, a);
            check("wr_data", wr_data_seen, d);
        end
        if (exp_rd != 0) check("rd_addr", rd_addr_seen, a);
        check("addr_hold", addr, m_addr);
        check("wdata_hold", wdata, m_wdata);
        check("busy_idle", 32'(busy), 32'd0);
        $display("txn op=%02h addr=%08h data=%08h tx_bytes=%0d err_pulses=%0d",
                 op, a, d, tx_q.size(), err_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_at;
        int waited;
        int n_tx, n_rd;
        logic [7:0]  op;
        logic [31:0] a;
        int k;

        idle(3);
        check_reset_outputs("rst_init");
        reset = 1'b1;
        idle(2);

        do_txn(8'h57, 32'h4000_000C, 32'h0000_00A5, 0, 3, 1'b0);
        do_txn(8'h52, 32'h4000_0010, 32'h0000_003C, 0, 3, 1'b0);
        do_txn(8'h41, 32'h0, 32'h0, 0, 0, 1'b1);
        do_txn(8'h52, 32'h4000_0002, 32'h0000_0055, 0, 3, 1'b0);
        // Every byte lands exactly on the timeout cycle: byte wins.
        do_txn(8'h57, 32'h4000_0020, 32'hCAFE_F00D, TMO - 1, TMO - 1, 1'b1);

        // Inter-byte timeout after 'W' 0x40.
        clear_mon();
        send_byte(8'h57);
        send_byte(8'h40);
        got_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (err && got_at == 0) got_at = i;
        end
        check("timeout_cycle", 32'(got_at), 32'(TMO));
        check("timeout_err_count", 32'(err_cnt), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_bus", 32'(wr_cnt + rd_cnt), 32'd0);
        check("timeout_tx", 32'(tx_q.size()), 32'd0);
        $display("txn timeout err_at_cycle=%0d", got_at);
        do_txn(8'h52, 32'h4000_0000, 32'h1234_5678, 0, 3, 1'b0);

        for (int t = 0; t < 40; t++) begin
            k = int'($urandom_range(9, 0));
            op = (k < 5) ? 8'h57 : (k < 9) ? 8'h52 : 8'($urandom);
            if (k >= 9 && (op == 8'h57 || op == 8'h52)) op = op ^ 8'h01;
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            else a[1:0] = 2'($urandom_range(3, 1));
            do_txn(op, a, $urandom, 0, 3, 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of a read response with tx_busy toggling.
        toggle_mode = 1'b1;
        clear_mon();
        rdata_val = 32'hA1B2_C3D4;
        send_byte(8'h52);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        waited = 0;
        while (tx_q.size() < 1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_tx", 32'(tx_q.size()), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd1);
        check("rst_mid_first", 32'(tx_q[0]), 32'hA1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        n_tx = tx_q.size();
        n_rd = rd_cnt;
        idle(3);
        check_reset_outputs("rst_hold");
        reset = 1'b1;
        idle(30);
        check("rst_no_more_tx", 32'(tx_q.size()), 32'(n_tx));
        check("rst_no_more_rd", 32'(rd_cnt), 32'(n_rd));
        check("rst_busy", 32'(busy), 32'd0);
        $display("txn reset_during_response tx_bytes_before_reset=%0d", n_tx);
        toggle_mode = 1'b0;
        m_addr = 32'h0;
        m_wdata = 32'h0;
        idle(6);
        do_txn(8'h57, 32'h0000_0100, 32'h0BAD_F00D, 0, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
